// File: rtl/fetch_queue.sv
// fetch_queue: small circular FIFO between instruction fetch and decode.
//
// Each cycle the fetched {pc, instr} pair is pushed whenever the queue is not
// full. pc_write_o tells the ProgramCounter it may advance, so PC and queue
// stay in lock-step without a combinational path back from decode.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   pc_i, instr_i       current PC and the instruction fetched at it
//   flush_i             redirect: drop every queued entry
//   deq_i               decode consumes the head entry
//   pc_write_o          1 = PC may advance (queue not full)
//   valid_o             head entry present
//   pc_o, instr_o       head entry (zero / NOP when empty)
//   count_o             occupied entries, 0..DEPTH
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      instr_i,
    input  logic             flush_i,
    input  logic             deq_i,
    output logic             pc_write_o,
    output logic             valid_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      instr_o,
    output logic [PTR_W:0]   count_o
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic full, empty, enq, deq;

    // Status comes from registered state only, so pc_write_o has no path
    // from deq_i or flush_i.
    always_comb begin
        full       = (count_q == DEPTH_C);
        empty      = (count_q == '0);
        pc_write_o = ~full;
        valid_o    = ~empty;
        enq        = ~full & ~flush_i;
        deq        = deq_i & ~empty & ~flush_i;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (enq) begin
            mem_d[wr_ptr_q] = '{pc: pc_i, instr: instr_i};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({enq, deq})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        // Redirect wins over push/pop; the target fetch lands next cycle.
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; stale data is masked by valid_o.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // No bypass: a freshly written entry is visible only after the edge.
    always_comb begin
        pc_o    = valid_o ? mem_q[rd_ptr_q].pc    : 32'h0;
        instr_o = valid_o ? mem_q[rd_ptr_q].instr : 32'h0;
        count_o = count_q;
    end

endmodule
